// File: rtl/alu_op_dispatch.sv
// Dispatch stage in front of the ALU units: accepts one request, enables exactly one unit
// for a single cycle, captures that unit's result and offers it on a valid/ready response port.
module alu_op_dispatch #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [WIDTH-1:0] unit_a,
   output logic [WIDTH-1:0] unit_b,
   output logic             en_or,
   output logic             en_and,
   output logic             en_xor,
   output logic             en_add,
   input  logic [WIDTH-1:0] res_or,
   input  logic [WIDTH-1:0] res_and,
   input  logic [WIDTH-1:0] res_xor,
   input  logic [WIDTH:0]   res_add,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [1:0]       rsp_op,
   output logic             rsp_zero,
   output logic             rsp_carry,
   output logic [CNT_W-1:0] ops_done
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   localparam logic [1:0] OP_OR  = 2'b00;
   localparam logic [1:0] OP_AND = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_ADD = 2'b11;

   state_t           state;
   logic [1:0]       op_q;
   logic             req_fire;
   logic             rsp_fire;
   logic [WIDTH-1:0] sel_data;
   logic             sel_carry;

   // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      req_ready = 1'b0;
      case (state)
         IDLE:    req_ready = 1'b1;
         DONE:    req_ready = rsp_ready;
         default: req_ready = 1'b0;
      endcase
   end

   assign req_fire = req_valid & req_ready;
   assign rsp_fire = rsp_valid & rsp_ready;

   assign en_or  = (state == EXEC) && (op_q == OP_OR);
   assign en_and = (state == EXEC) && (op_q == OP_AND);
   assign en_xor = (state == EXEC) && (op_q == OP_XOR);
   assign en_add = (state == EXEC) && (op_q == OP_ADD);

   // Only the enabled unit's bus is looked at; the others may be X.
   always_comb begin
      sel_data  = '0;
      sel_carry = 1'b0;
      case (op_q)
         OP_OR:   sel_data = res_or;
         OP_AND:  sel_data = res_and;
         OP_XOR:  sel_data = res_xor;
         default: begin
            sel_data  = res_add[WIDTH-1:0];
            sel_carry = res_add[WIDTH];
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_q      <= OP_OR;
         unit_a    <= '0;
         unit_b    <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_op    <= '0;
         rsp_zero  <= 1'b0;
         rsp_carry <= 1'b0;
         ops_done  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_fire) begin
                  op_q   <= req_op;
                  unit_a <= req_a;
                  unit_b <= req_b;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               rsp_data  <= sel_data;
               rsp_op    <= op_q;
               rsp_zero  <= (sel_data == '0);
               rsp_carry <= sel_carry;
               rsp_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (rsp_fire) begin
                  ops_done  <= ops_done + 1'b1;
                  rsp_valid <= 1'b0;
                  // req_ready follows rsp_ready here, so a new request can only land with the handshake.
                  if (req_fire) begin
                     op_q   <= req_op;
                     unit_a <= req_a;
                     unit_b <= req_b;
                     state  <= EXEC;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_dispatch.sv
// Bench for alu_op_dispatch: behavioural ALU units drive X when disabled; results are
// predicted from plain arithmetic and compared at the falling clock edge.
module tb_alu_op_dispatch;

   localparam int WIDTH = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [WIDTH-1:0] unit_a;
   logic [WIDTH-1:0] unit_b;
   logic             en_or;
   logic             en_and;
   logic             en_xor;
   logic             en_add;
   logic [WIDTH-1:0] res_or;
   logic [WIDTH-1:0] res_and;
   logic [WIDTH-1:0] res_xor;
   logic [WIDTH:0]   res_add;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic [1:0]       rsp_op;
   logic             rsp_zero;
   logic             rsp_carry;
   logic [CNT_W-1:0] ops_done;

   int checks = 0;
   int errors = 0;
   int exp_done = 0;

   always #5 clk = ~clk;

   alu_op_dispatch #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .unit_a(unit_a), .unit_b(unit_b),
      .en_or(en_or), .en_and(en_and), .en_xor(en_xor), .en_add(en_add),
      .res_or(res_or), .res_and(res_and), .res_xor(res_xor), .res_add(res_add),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_op(rsp_op), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
      .ops_done(ops_done)
   );

   // Behavioural units: real result only while enabled, X otherwise.
   assign res_or  = en_or  ? (unit_a | unit_b) : 'x;
   assign res_and = en_and ? (unit_a & unit_b) : 'x;
   assign res_xor = en_xor ? (unit_a ^ unit_b) : 'x;
   assign res_add = en_add ? ({1'b0, unit_a} + {1'b0, unit_b}) : 'x;

   // Reference result {carry, data} from the opcode rules with integer arithmetic.
   function automatic logic [WIDTH:0] ref_result(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      int sum;
      case (op)
         2'b00:   return {1'b0, a | b};
         2'b01:   return {1'b0, a & b};
         2'b10:   return {1'b0, a ^ b};
         default: begin
            sum = int'(a) + int'(b);
            return {sum >= (1 << WIDTH), WIDTH'(sum % (1 << WIDTH))};
         end
      endcase
   endfunction

   // Expected {en_or, en_and, en_xor, en_add} while an op executes.
   function automatic logic [3:0] ref_en(input logic [1:0] op);
      case (op)
         2'b00:   return 4'b1000;
         2'b01:   return 4'b0100;
         2'b10:   return 4'b0010;
         default: return 4'b0001;
      endcase
   endfunction

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checks++;
         if ((int'(en_or) + int'(en_and) + int'(en_xor) + int'(en_add)) > 1) begin
            errors++;
            $display("FAIL onehot: en=%b%b%b%b required at most one high", en_or, en_and, en_xor, en_add);
         end
         checks++;
         if ($isunknown({req_ready, unit_a, unit_b, en_or, en_and, en_xor, en_add, rsp_valid,
                         rsp_data, rsp_op, rsp_zero, rsp_carry, ops_done})) begin
            errors++;
            $display("FAIL no_x: outputs carry X, rsp_data=%b ops_done=%b required known", rsp_data, ops_done);
         end
      end
   end

   // One complete transaction, holding rsp_ready low for 'hold' cycles once the response is up.
   task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int hold, input string name);
      logic [WIDTH:0]   exp;
      logic [WIDTH-1:0] snap_data;
      logic [1:0]       snap_op;
      logic             snap_zero;
      logic             snap_carry;
      int               n;
      exp = ref_result(op, a, b);
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b; rsp_ready = 1'b0;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s accept: req_ready=%b required 1 within 20 cycles", name, req_ready);
         req_valid = 1'b0;
         return;
      end
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if ({en_or, en_and, en_xor, en_add} !== ref_en(op) || rsp_valid !== 1'b0 || req_ready !== 1'b0 ||
          unit_a !== a || unit_b !== b) begin
         errors++;
         $display("FAIL %s exec: en=%b rsp_valid=%b req_ready=%b unit_a=%h unit_b=%h required en=%b 0 0 %h %h",
                  name, {en_or, en_and, en_xor, en_add}, rsp_valid, req_ready, unit_a, unit_b,
                  ref_en(op), a, b);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp[WIDTH-1:0] || rsp_op !== op ||
          rsp_zero !== (exp[WIDTH-1:0] == '0) || rsp_carry !== exp[WIDTH]) begin
         errors++;
         $display("FAIL %s rsp: valid=%b data=%h op=%b zero=%b carry=%b required 1 %h %b %b %b",
                  name, rsp_valid, rsp_data, rsp_op, rsp_zero, rsp_carry, exp[WIDTH-1:0], op,
                  exp[WIDTH-1:0] == '0, exp[WIDTH]);
      end
      checks++;
      if ({en_or, en_and, en_xor, en_add} !== 4'b0000 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s done_idle: en=%b req_ready=%b required 0000 0", name,
                  {en_or, en_and, en_xor, en_add}, req_ready);
      end
      snap_data = rsp_data; snap_op = rsp_op; snap_zero = rsp_zero; snap_carry = rsp_carry;
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1; req_op = 2'($urandom); req_a = ~a; req_b = ~b;
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== snap_data || rsp_op !== snap_op ||
             rsp_zero !== snap_zero || rsp_carry !== snap_carry || req_ready !== 1'b0 ||
             {en_or, en_and, en_xor, en_add} !== 4'b0000 || unit_a !== a || unit_b !== b) begin
            errors++;
            $display("FAIL %s hold%0d: valid=%b data=%h req_ready=%b en=%b unit_a=%h required 1 %h 0 0000 %h",
                     name, i, rsp_valid, rsp_data, req_ready, {en_or, en_and, en_xor, en_add},
                     unit_a, snap_data, a);
         end
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      exp_done++;
      checks++;
      if (rsp_valid !== 1'b0 || ops_done !== CNT_W'(exp_done % (1 << CNT_W))) begin
         errors++;
         $display("FAIL %s consume: rsp_valid=%b ops_done=%0d required 0 %0d", name, rsp_valid,
                  ops_done, exp_done % (1 << CNT_W));
      end
   endtask

   task automatic test_reset();
      checks++;
      if (rsp_valid !== 1'b0 || {en_or, en_and, en_xor, en_add} !== 4'b0000 || unit_a !== '0 ||
          unit_b !== '0 || rsp_data !== '0 || rsp_op !== 2'b00 || rsp_zero !== 1'b0 ||
          rsp_carry !== 1'b0 || ops_done !== '0) begin
         errors++;
         $display("FAIL reset: valid=%b en=%b a=%h b=%h data=%h op=%b z=%b c=%b done=%0d required all zero",
                  rsp_valid, {en_or, en_and, en_xor, en_add}, unit_a, unit_b, rsp_data, rsp_op,
                  rsp_zero, rsp_carry, ops_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
      end
   endtask

   task automatic test_or();
      run_op(2'b00, 4'b1010, 4'b0101, 0, "or");
   endtask

   task automatic test_add_carry();
      run_op(2'b11, 4'hF, 4'h1, 0, "add_carry");
   endtask

   task automatic test_backpressure();
      run_op(2'b10, 4'h6, 4'h6, 5, "xor_bp");
   endtask

   task automatic test_back_to_back();
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b01; req_a = 4'hC; req_b = 4'hA; rsp_ready = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 4'h8 || rsp_op !== 2'b01 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first: valid=%b data=%h op=%b req_ready=%b required 1 8 01 1",
                  rsp_valid, rsp_data, rsp_op, req_ready);
      end
      req_valid = 1'b1; req_op = 2'b00; req_a = 4'h1; req_b = 4'h2;
      @(negedge clk);
      req_valid = 1'b0;
      exp_done++;
      checks++;
      if (rsp_valid !== 1'b0 || {en_or, en_and, en_xor, en_add} !== 4'b1000 ||
          ops_done !== CNT_W'(exp_done % (1 << CNT_W))) begin
         errors++;
         $display("FAIL b2b_exec: valid=%b en=%b ops_done=%0d required 0 1000 %0d", rsp_valid,
                  {en_or, en_and, en_xor, en_add}, ops_done, exp_done % (1 << CNT_W));
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 4'h3 || rsp_op !== 2'b00 || rsp_zero !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second: valid=%b data=%h op=%b zero=%b required 1 3 00 0", rsp_valid,
                  rsp_data, rsp_op, rsp_zero);
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      exp_done++;
      checks++;
      if (rsp_valid !== 1'b0 || ops_done !== CNT_W'(exp_done % (1 << CNT_W))) begin
         errors++;
         $display("FAIL b2b_end: valid=%b ops_done=%0d required 0 %0d", rsp_valid, ops_done,
                  exp_done % (1 << CNT_W));
      end
   endtask

   task automatic test_reset_exec();
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b11; req_a = 4'h9; req_b = 4'h9; rsp_ready = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (en_add !== 1'b1) begin
         errors++;
         $display("FAIL rst_exec_pre: en_add=%b required 1", en_add);
      end
      #1 rst_n = 1'b0;
      #1;
      exp_done = 0;
      checks++;
      if (rsp_valid !== 1'b0 || {en_or, en_and, en_xor, en_add} !== 4'b0000 || unit_a !== '0 ||
          unit_b !== '0 || rsp_data !== '0 || rsp_op !== 2'b00 || rsp_carry !== 1'b0 ||
          ops_done !== '0) begin
         errors++;
         $display("FAIL rst_exec: valid=%b en=%b a=%h data=%h op=%b c=%b done=%0d required all zero",
                  rsp_valid, {en_or, en_and, en_xor, en_add}, unit_a, rsp_data, rsp_op, rsp_carry,
                  ops_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0 || {en_or, en_and, en_xor, en_add} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_exec_after%0d: valid=%b en=%b required 0 0000", i, rsp_valid,
                     {en_or, en_and, en_xor, en_add});
         end
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_random_wrap();
      for (int i = 0; i < (1 << CNT_W); i++) begin
         run_op(2'($urandom), WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 2)), "rand");
      end
      checks++;
      if (ops_done !== '0) begin
         errors++;
         $display("FAIL wrap: ops_done=%0d required 0", ops_done);
      end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_or();
      test_add_carry();
      test_backpressure();
      test_back_to_back();
      test_reset_exec();
      test_random_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
